// File: rtl/fir_uart_tx.sv
// fir_uart_tx: buffers 32-bit AXI-Stream words in a small FIFO and sends each as 4 UART bytes, LSB byte first.
// Define FIR_UART_TX_PARITY_EN to add an even-parity bit after the data bits (8E1 instead of 8N1).
module fir_uart_tx #(
    parameter int CLK_DIV    = 347,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        ss_tvalid,
    input  logic [31:0] ss_tdata,
    output logic        ss_tready,
    input  logic        tx_en,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] word_cnt,
    output logic [2:0]  dbg_state
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BIT_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Handshake: a word moves on a rising edge where ss_tvalid and ss_tready are both 1;
    // ss_tready comes straight from a flop and never depends on ss_tvalid.
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    logic          push, pop;

    state_t      state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] shreg_q;
    logic        tx_q;
    logic [15:0] word_cnt_q;
    logic        bit_done;
`ifdef FIR_UART_TX_PARITY_EN
    logic        parity_q;
`endif

    assign push     = ss_tvalid & ready_q;
    assign pop      = (state_q == S_IDLE) & (count_q != '0) & tx_en;
    assign bit_done = (timer_q == BIT_LAST);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            // Computed from next occupancy, so a pop from full raises ready one cycle later.
            ready_q <= (count_d != FULL_CNT);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_ptr_q] <= ss_tdata;
    end

    // The line flop follows the state one cycle behind, so every bit lasts exactly CLK_DIV cycles.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            word_cnt_q <= '0;
`ifdef FIR_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE) timer_q <= '0;
            else                   timer_q <= bit_done ? 16'd0 : timer_q + 16'd1;

            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shreg_q    <= mem_q[rd_ptr_q];
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
`ifdef FIR_UART_TX_PARITY_EN
                    parity_q <= 1'b0;
`endif
                    if (bit_done) state_q <= S_DATA;
                end
                S_DATA: begin
                    tx_q <= shreg_q[0];
                    if (bit_done) begin
                        shreg_q   <= {1'b0, shreg_q[31:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
`ifdef FIR_UART_TX_PARITY_EN
                        parity_q  <= parity_q ^ shreg_q[0];
                        if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
                    end
                end
`ifdef FIR_UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_q <= parity_q;
                    if (bit_done) state_q <= S_STOP;
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_done) begin
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            state_q    <= S_START;
                        end else begin
                            word_cnt_q <= word_cnt_q + 16'd1;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ss_tready = ready_q;
    assign uart_tx   = tx_q;
    assign busy      = (state_q != S_IDLE) | (count_q != '0);
    assign word_cnt  = word_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_uart_tx.sv
// Bench for fir_uart_tx: UART receiver at the pin feeds a byte scoreboard; table vectors, corner sequences, random words.
module tb_fir_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef FIR_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BYTE_CYC = FRAME_BITS * CLK_DIV;
  localparam int WORD_GAP = 4 * BYTE_CYC + 1;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b1;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        tx_en = 1'b0;
  logic        ss_tready, uart_tx, busy;
  logic [15:0] word_cnt;
  logic [2:0]  dbg_state;

  fir_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .tx_en(tx_en), .uart_tx(uart_tx), .busy(busy), .word_cnt(word_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 axis_clk = ~axis_clk;
  int cyc = 0;
  always @(posedge axis_clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];   // {parity, byte} in line order
  int          start_q[$]; // cycle at which each start bit was seen
  logic [15:0] exp_words = '0;

  typedef struct packed {
    logic [31:0]     word;
    logic [3:0][7:0] bytes;
    logic [3:0]      par;
  } vec_t;
  vec_t vecs [4];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // scoreboard: one decoded frame against the head of the expected queue
  function automatic void frame_done(input logic [10:0] b);
    logic [8:0] e;
    chk("start_bit", 32'(b[0]), 32'd0);
    chk("stop_bit", 32'(b[FRAME_BITS-1]), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame (cycle %0d)", b[8:1], cyc);
    end else begin
      e = exp_q.pop_front();
      chk("rx_byte", 32'(b[8:1]), 32'(e[7:0]));
`ifdef FIR_UART_TX_PARITY_EN
      chk("parity_bit", 32'(b[9]), 32'(e[8]));
`endif
    end
  endfunction

  // receiver: samples the line mid-bit on falling clock edges
  int         rx_cyc = 0;
  bit         rx_busy = 1'b0;
  logic [10:0] rx_bits = '0;
  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (uart_tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cyc  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cyc++;
      if (rx_cyc % CLK_DIV == CLK_DIV / 2) begin
        rx_bits[rx_cyc / CLK_DIV] = uart_tx;
        if (rx_cyc / CLK_DIV == FRAME_BITS - 1) begin
          rx_busy = 1'b0;
          frame_done(rx_bits);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axis_clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'((w >> (8 * i)) & 32'hFF);
      exp_q.push_back({^b, b});
    end
    exp_words = exp_words + 16'd1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int budget;
    budget = 4000;
    ss_tvalid = 1'b1;
    ss_tdata  = w;
    while (ss_tready !== 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (ss_tready !== 1'b1) begin
      chk("push_timeout", 32'(ss_tready), 32'd1);
      ss_tvalid = 1'b0;
    end else begin
      tick(1);
      ss_tvalid = 1'b0;
    end
  endtask

  task automatic wait_words(input logic [15:0] target, input int budget);
    while (word_cnt !== target && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("word_cnt_reach", 32'(word_cnt), 32'(target));
    tick(4);
  endtask

  task automatic wait_starts(input int n);
    int budget;
    budget = 2000;
    while (start_q.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("start_seen", 32'(start_q.size() >= n), 32'd1);
  endtask

  logic [31:0] fw [6];
  logic [31:0] w;
  bit          late_done;
  logic [15:0] base;

  initial begin
    vecs[0] = '{32'h0000_AB61, {8'h00, 8'h00, 8'hAB, 8'h61}, 4'b0011};
    vecs[1] = '{32'h0000_0003, {8'h00, 8'h00, 8'h00, 8'h03}, 4'b0000};
    vecs[2] = '{32'h0000_0007, {8'h00, 8'h00, 8'h00, 8'h07}, 4'b0001};
    vecs[3] = '{32'h80FF_5A01, {8'h80, 8'hFF, 8'h5A, 8'h01}, 4'b1001};

    // reset
    #2 axis_rst_n = 1'b0;
    tick(3);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_ready", 32'(ss_tready), 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(ss_tready), 32'd0);
    tick(1);
    chk("ready_after_release", 32'(ss_tready), 32'd1);
    tick(2);

    // table vectors: single words, latency, byte spacing
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back({vecs[i].par[k], vecs[i].bytes[k]});
      exp_words = exp_words + 16'd1;
      push_word(vecs[i].word);
      chk("lat_edge_n", 32'(uart_tx), 32'd1);
      tick(1);
      chk("lat_edge_n1", 32'(uart_tx), 32'd1);
      tick(1);
      chk("lat_edge_n2", 32'(uart_tx), 32'd0);
      wait_words(exp_words, 1000);
      chk("busy_after", 32'(busy), 32'd0);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      chk("frame_count", 32'(start_q.size()), 32'd4);
      if (start_q.size() == 4)
        for (int k = 1; k < 4; k++) chk("byte_spacing", 32'(start_q[k] - start_q[k-1]), 32'(BYTE_CYC));
    end

    // fill with tx_en=0, then drain; ready rises only the cycle after a pop from full
    tx_en = 1'b0;
    start_q.delete();
    base = exp_words;
    for (int i = 0; i < 6; i++) fw[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      push_word(fw[i]);
      expect_word(fw[i]);
      chk("fill_ready", 32'(ss_tready), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("fill_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("fill_line_idle", 32'(uart_tx), 32'd1);
    end
    expect_word(fw[4]);
    expect_word(fw[5]);
    late_done = 1'b0;
    fork
      begin
        push_word(fw[4]);
        push_word(fw[5]);
        late_done = 1'b1;
      end
    join_none
    tx_en = 1'b1;
    chk("full_ready_pre_pop", 32'(ss_tready), 32'd0);
    tick(1);
    chk("full_ready_post_pop", 32'(ss_tready), 32'd1);
    wait_words(base + 16'd6, 6000);
    chk("late_pushes_done", 32'(late_done), 32'd1);
    chk("fill_bytes_left", 32'(exp_q.size()), 32'd0);
    chk("fill_frames", 32'(start_q.size()), 32'd24);
    if (start_q.size() == 24)
      for (int k = 1; k < 6; k++) chk("word_gap", 32'(start_q[4*k] - start_q[4*(k-1)]), 32'(WORD_GAP));

    // tx_en dropped during byte 2: word finishes, rest stays queued
    tx_en = 1'b0;
    start_q.delete();
    base = exp_words;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      push_word(w);
      expect_word(w);
    end
    tx_en = 1'b1;
    wait_starts(2);
    tick(6);
    tx_en = 1'b0;
    wait_words(base + 16'd1, 1000);
    tick(200);
    chk("hold_word_cnt", 32'(word_cnt), 32'(base + 16'd1));
    chk("hold_frames", 32'(start_q.size()), 32'd4);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_line", 32'(uart_tx), 32'd1);
    chk("hold_queued_bytes", 32'(exp_q.size()), 32'd8);
    tx_en = 1'b1;
    wait_words(base + 16'd3, 2000);
    chk("resume_bytes_left", 32'(exp_q.size()), 32'd0);
    chk("resume_frames", 32'(start_q.size()), 32'd12);

    // reset pulse in the middle of a data bit
    start_q.delete();
    push_word({$urandom_range(0, 32'hFFFF), 16'h0000});
    push_word($urandom);
    wait_starts(1);
    tick(CLK_DIV * 2 + 1);
    chk("pre_reset_line_low", 32'(uart_tx), 32'd0);
    #2 axis_rst_n = 1'b0;
    #1;
    chk("async_rst_line", 32'(uart_tx), 32'd1);
    chk("async_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(ss_tready), 32'd0);
    exp_q.delete();
    exp_words = '0;
    tick(2);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    tick(100);
    chk("post_rst_no_frames", 32'(start_q.size()), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    exp_q.push_back({1'b1, 8'hB5});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 8'hFF});
    exp_words = 16'd1;
    push_word(32'hFFFF_FFB5);
    wait_words(16'd1, 1000);
    chk("post_rst_bytes_left", 32'(exp_q.size()), 32'd0);

    // random words, random gaps and tx_en, against the byte-level model
    for (int i = 0; i < 16; i++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 40));
      if (ss_tready !== 1'b1) tx_en = 1'b1;
      w = $urandom;
      push_word(w);
      expect_word(w);
    end
    tx_en = 1'b1;
    wait_words(exp_words, 20000);
    chk("rand_bytes_left", 32'(exp_q.size()), 32'd0);
    chk("rand_busy", 32'(busy), 32'd0);
    chk("rand_line_idle", 32'(uart_tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to be done", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
